roi_pool_core: RTL and testbench

ROI_POOL_CORE -- requirements
Module: roi_pool_core

---
 rtl/roi_pool_core.sv | 161 ++++++++++++++++
 tb/tb_roi_pool_core.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/roi_pool_core.sv
// rtl/roi_pool_core.sv - fixed centre-ROI average/max pooling with one-cycle video passthrough
// Optional ROI_BORDER_EN: vid_data shows the ROI perimeter as 4'hF during capture frames.
`timescale 1ns/1ps
module roi_pool_core #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int POOL_W = 8,
    parameter int POOL_H = 8,
    parameter int OUT_N  = 28,
    parameter int PIX_W  = 8
) (
    input  logic                             clk25,
    input  logic                             rst_n,
    input  logic                             sof,
    input  logic                             pix_valid,
    input  logic [PIX_W-1:0]                 pix_data,
    input  logic                             mode,
    input  logic                             capture_en,
    output logic                             vid_valid,
    output logic [3:0]                       vid_data,
    output logic                             pool_valid,
    input  logic                             pool_ready,
    output logic [7:0]                       pool_data,
    output logic [$clog2(OUT_N*OUT_N)-1:0]   pool_addr,
    output logic                             frame_done,
    output logic                             overrun
);
    localparam int AW    = $clog2(OUT_N*OUT_N);
    localparam int HW    = $clog2(IMG_W);
    localparam int VW    = $clog2(IMG_H);
    localparam int NPIX  = POOL_W*POOL_H;
    localparam int LOGN  = $clog2(NPIX);
    localparam int ACC_W = PIX_W + LOGN;
    localparam int ROI_W = POOL_W*OUT_N;
    localparam int ROI_H = POOL_H*OUT_N;
    localparam int LEFT  = IMG_W/2 - ROI_W/2;
    localparam int UPPER = IMG_H/2 - ROI_H/2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic             mode_q, cap_q;
    logic [ACC_W-1:0] acc [OUT_N];

    logic             running, accept, mode_e, cap_e, in_roi;
    logic             top_left, bot_right, hit, complete, last_pix, held;
    logic [HW-1:0]    eh;
    logic [VW-1:0]    ev;
    int               dx, dy, col, row;
    logic [ACC_W-1:0] cur, pix_ext, acc_nx, rnd;
    logic [PIX_W-1:0] res;
    logic [3:0]       vid_nx;

    assign frame_done = (state == DONE);

    // A pixel arriving with sof is already (0,0) of the new frame, so sof overrides the held context.
    always_comb begin
        running   = sof || (state == RUN);
        accept    = pix_valid && running;
        eh        = sof ? '0 : h_cnt;
        ev        = sof ? '0 : v_cnt;
        mode_e    = sof ? mode : mode_q;
        cap_e     = sof ? capture_en : cap_q;
        dx        = int'(eh) - LEFT;
        dy        = int'(ev) - UPPER;
        in_roi    = (dx >= 0) && (dx < ROI_W) && (dy >= 0) && (dy < ROI_H);
        col       = dx / POOL_W;
        row       = dy / POOL_H;
        top_left  = (dx % POOL_W == 0) && (dy % POOL_H == 0);
        bot_right = (dx % POOL_W == POOL_W-1) && (dy % POOL_H == POOL_H-1);
        hit       = accept && cap_e && in_roi;
        complete  = hit && bot_right;
        last_pix  = (int'(eh) == IMG_W-1) && (int'(ev) == IMG_H-1);
        held      = sof ? 1'b0 : pool_valid;
        cur       = '0;
        for (int i = 0; i < OUT_N; i++)
            if (col == i) cur = acc[i];
        pix_ext   = ACC_W'(pix_data);
        if (top_left)
            acc_nx = pix_ext;
        else if (mode_e)
            acc_nx = (pix_ext > cur) ? pix_ext : cur;
        else
            acc_nx = cur + pix_ext;
        rnd       = acc_nx + ACC_W'(NPIX/2);
        res       = mode_e ? acc_nx[PIX_W-1:0] : PIX_W'(rnd >> LOGN);
`ifdef ROI_BORDER_EN
        vid_nx = (cap_e && running && in_roi &&
                  (dx == 0 || dx == ROI_W-1 || dy == 0 || dy == ROI_H-1))
                 ? 4'hF : pix_data[PIX_W-1 -: 4];
`else
        vid_nx = pix_data[PIX_W-1 -: 4];
`endif
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            h_cnt      <= '0;
            v_cnt      <= '0;
            mode_q     <= 1'b0;
            cap_q      <= 1'b0;
            vid_valid  <= 1'b0;
            vid_data   <= '0;
            pool_valid <= 1'b0;
            pool_data  <= '0;
            pool_addr  <= '0;
            overrun    <= 1'b0;
            for (int i = 0; i < OUT_N; i++) acc[i] <= '0;
        end else begin
            vid_valid <= pix_valid;
            vid_data  <= vid_nx;

            if (sof) begin
                state  <= (accept && last_pix) ? DONE : RUN;
                mode_q <= mode;
                cap_q  <= capture_en;
            end else if (state == RUN) begin
                if (accept && last_pix) state <= DONE;
            end else if (state == DONE) begin
                state <= IDLE;
            end

            if (accept) begin
                if (int'(eh) == IMG_W-1) begin
                    h_cnt <= '0;
                    v_cnt <= (int'(ev) == IMG_H-1) ? '0 : ev + VW'(1);
                end else begin
                    h_cnt <= eh + HW'(1);
                    v_cnt <= ev;
                end
            end else if (sof) begin
                h_cnt <= '0;
                v_cnt <= '0;
            end

            for (int i = 0; i < OUT_N; i++) begin
                if (hit && col == i)
                    acc[i] <= acc_nx;
                else if (sof)
                    acc[i] <= '0;
            end

            // A result finishing against an unaccepted held one is dropped; the held one wins.
            overrun <= sof ? 1'b0 : overrun;
            if (complete && held && !pool_ready) begin
                overrun <= 1'b1;
            end else if (complete) begin
                pool_valid <= 1'b1;
                pool_data  <= res[PIX_W-1 -: 8];
                pool_addr  <= AW'(row*OUT_N + col);
            end else if (sof || (pool_valid && pool_ready)) begin
                pool_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_roi_pool_core.sv
// tb/tb_roi_pool_core.sv - table, directed and randomized frame checks for roi_pool_core
`timescale 1ns/1ps
module tb_roi_pool_core;
    localparam int IW = 16, IH = 8, PW = 2, PH = 2, ON = 4, PXW = 8;
    localparam int RL = IW/2 - PW*ON/2;
    localparam int RR = RL + PW*ON;
    localparam int RU = IH/2 - PH*ON/2;
    localparam int RD = RU + PH*ON;

    logic       clk25 = 1'b0;
    logic       rst_n, sof, pix_valid, mode, capture_en, pool_ready;
    logic [7:0] pix_data;
    logic       vid_valid, pool_valid, frame_done, overrun;
    logic [3:0] vid_data, pool_addr;
    logic [7:0] pool_data;

    roi_pool_core #(.IMG_W(IW), .IMG_H(IH), .POOL_W(PW), .POOL_H(PH), .OUT_N(ON), .PIX_W(PXW)) dut (
        .clk25(clk25), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_data(pix_data),
        .mode(mode), .capture_en(capture_en), .vid_valid(vid_valid), .vid_data(vid_data),
        .pool_valid(pool_valid), .pool_ready(pool_ready), .pool_data(pool_data),
        .pool_addr(pool_addr), .frame_done(frame_done), .overrun(overrun)
    );

    always #20 clk25 = ~clk25;

    typedef struct { int addr; int data; } res_t;
    typedef struct {
        logic m; logic [7:0] bg; int sx; int sy; logic [7:0] sv; int sa; logic [7:0] se; logic [7:0] oe;
    } vec_t;

    res_t       res_q[$];
    int         fd_tot = 0;
    int         nchk = 0, nerr = 0;
    logic [7:0] img [IH][IW];
    logic [3:0] vid_seen [IH][IW];
    int         exp_res [ON*ON];
    vec_t       tbl [6];

    always @(negedge clk25) begin
        if (pool_valid && pool_ready) res_q.push_back('{int'(pool_addr), int'(pool_data)});
        if (frame_done) fd_tot <= fd_tot + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic ref_pool(input logic m);
        for (int r = 0; r < ON; r++)
            for (int c = 0; c < ON; c++) begin
                int s, mx;
                s = 0; mx = 0;
                for (int y = 0; y < PH; y++)
                    for (int x = 0; x < PW; x++) begin
                        int p;
                        p = int'(img[RU + r*PH + y][RL + c*PW + x]);
                        s += p;
                        if (p > mx) mx = p;
                    end
                exp_res[r*ON + c] = m ? mx : (s + PW*PH/2) / (PW*PH);
            end
    endtask

    task automatic idle_cycle(inout int bad);
        pix_valid = 1'b0;
        pix_data  = 8'($urandom);
        @(posedge clk25); #1;
        if (vid_valid !== 1'b0) bad++;
        mode = 1'($urandom); capture_en = 1'($urandom);
    endtask

    task automatic run_frame(input int npix, input logic m, input logic cap, input logic rdy, input int gap);
        int bad;
        logic [3:0] expv;
        bad = 0;
        pool_ready = rdy;
        for (int n = 0; n < npix; n++) begin
            int h, v;
            h = n % IW; v = n / IW;
            if (n > 0 && $urandom_range(0, 99) < gap) idle_cycle(bad);
            sof = (n == 0); pix_valid = 1'b1; pix_data = img[v][h];
            if (n == 0) begin mode = m; capture_en = cap; end
            @(posedge clk25); #1;
            expv = img[v][h][7:4];
`ifdef ROI_BORDER_EN
            if (cap && h >= RL && h < RR && v >= RU && v < RD &&
                (h == RL || h == RR-1 || v == RU || v == RD-1)) expv = 4'hF;
`endif
            vid_seen[v][h] = vid_data;
            if (vid_valid !== 1'b1 || vid_data !== expv) bad++;
            sof = 1'b0; mode = 1'($urandom); capture_en = 1'($urandom);
        end
        repeat (4) idle_cycle(bad);
        chk("video_passthrough_errors", bad, 0);
    endtask

    task automatic check_results(input string tag, input int base, input int fd0, input int nexp);
        int n;
        n = res_q.size() - base;
        chk({tag, "_count"}, n, nexp);
        for (int i = 0; i < n && i < nexp; i++) begin
            chk({tag, "_addr"}, res_q[base+i].addr, i);
            chk({tag, "_data"}, res_q[base+i].data, exp_res[i]);
        end
        chk({tag, "_frame_done"}, fd_tot - fd0, 1);
    endtask

    task automatic rand_img();
        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++) img[y][x] = 8'($urandom);
    endtask

    initial begin
        int base, fd0;
        logic m;
        logic [3:0] eb;
        tbl[0] = '{1'b0, 8'h80, 5, 1, 8'h80, 0, 8'h80, 8'h80};
        tbl[1] = '{1'b1, 8'h10, 5, 1, 8'hFF, 0, 8'hFF, 8'h10};
        tbl[2] = '{1'b0, 8'h10, 5, 1, 8'hFF, 0, 8'h4C, 8'h10};
        tbl[3] = '{1'b1, 8'h00, 11, 7, 8'h01, 15, 8'h01, 8'h00};
        tbl[4] = '{1'b0, 8'hFF, 0, 0, 8'h00, 0, 8'hFF, 8'hFF};
        tbl[5] = '{1'b0, 8'h01, 10, 6, 8'h03, 15, 8'h02, 8'h01};

        rst_n = 1'b0; sof = 1'b0; pix_valid = 1'b0; pix_data = 8'h00;
        mode = 1'b0; capture_en = 1'b0; pool_ready = 1'b1;
        repeat (3) @(posedge clk25); #1;
        chk("reset_pool_valid", int'(pool_valid), 0);
        chk("reset_pool_data", int'(pool_data), 0);
        chk("reset_pool_addr", int'(pool_addr), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        chk("reset_overrun", int'(overrun), 0);
        chk("reset_vid_valid", int'(vid_valid), 0);
        chk("reset_vid_data", int'(vid_data), 0);
        rst_n = 1'b1;

        for (int t = 0; t < 6; t++) begin
            for (int y = 0; y < IH; y++)
                for (int x = 0; x < IW; x++) img[y][x] = tbl[t].bg;
            img[tbl[t].sy][tbl[t].sx] = tbl[t].sv;
            for (int i = 0; i < ON*ON; i++) exp_res[i] = (i == tbl[t].sa) ? int'(tbl[t].se) : int'(tbl[t].oe);
            base = res_q.size(); fd0 = fd_tot;
            run_frame(IW*IH, tbl[t].m, 1'b1, 1'b1, 20);
            check_results($sformatf("table%0d", t), base, fd0, ON*ON);
        end

        for (int y = 0; y < IH; y++)
            for (int x = 0; x < IW; x++) img[y][x] = 8'h00;
        img[0][4] = 8'd1; img[0][5] = 8'd1; img[1][4] = 8'd1; img[1][5] = 8'd2;
        img[0][6] = 8'd1; img[0][7] = 8'd2; img[1][6] = 8'd2; img[1][7] = 8'd2;
        img[0][0] = 8'hA7;
        for (int i = 0; i < ON*ON; i++) exp_res[i] = 0;
        exp_res[0] = 1; exp_res[1] = 2;
        base = res_q.size(); fd0 = fd_tot;
        run_frame(IW*IH, 1'b0, 1'b1, 1'b1, 0);
        check_results("rounding", base, fd0, ON*ON);
`ifdef ROI_BORDER_EN
        eb = 4'hF;
`else
        eb = 4'h0;
`endif
        chk("vid_at_4_0", int'(vid_seen[0][4]), int'(eb));
        chk("vid_at_11_5", int'(vid_seen[5][11]), int'(eb));
        chk("vid_at_0_0", int'(vid_seen[0][0]), 10);

        for (int f = 0; f < 6; f++) begin
            rand_img();
            m = 1'($urandom);
            ref_pool(m);
            base = res_q.size(); fd0 = fd_tot;
            run_frame(IW*IH, m, f != 5, 1'b1, 30);
            check_results($sformatf("random%0d", f), base, fd0, (f != 5) ? ON*ON : 0);
        end

        rand_img();
        ref_pool(1'b0);
        run_frame(IW*IH, 1'b0, 1'b1, 1'b0, 10);
        chk("held_pool_valid", int'(pool_valid), 1);
        chk("held_pool_addr", int'(pool_addr), 0);
        chk("held_pool_data", int'(pool_data), exp_res[0]);
        chk("held_overrun", int'(overrun), 1);
        sof = 1'b1; pix_valid = 1'b0;
        @(posedge clk25); #1;
        sof = 1'b0;
        chk("sof_clears_pool_valid", int'(pool_valid), 0);
        chk("sof_clears_overrun", int'(overrun), 0);

        fd0 = fd_tot;
        rand_img();
        run_frame(40, 1'b1, 1'b1, 1'b1, 0);
        chk("aborted_frame_done", fd_tot - fd0, 0);
        rand_img();
        ref_pool(1'b1);
        base = res_q.size(); fd0 = fd_tot;
        run_frame(IW*IH, 1'b1, 1'b1, 1'b1, 25);
        check_results("after_abort", base, fd0, ON*ON);

        rand_img();
        run_frame(50, 1'b0, 1'b1, 1'b1, 0);
        rst_n = 1'b0;
        @(posedge clk25); #1;
        chk("midreset_pool_valid", int'(pool_valid), 0);
        chk("midreset_frame_done", int'(frame_done), 0);
        rst_n = 1'b1;
        base = res_q.size(); fd0 = fd_tot;
        for (int n = 0; n < IW*IH; n++) begin
            pix_valid = 1'b1; pix_data = 8'($urandom);
            @(posedge clk25); #1;
        end
        pix_valid = 1'b0;
        repeat (4) @(posedge clk25);
        #1;
        chk("no_sof_results", res_q.size() - base, 0);
        chk("no_sof_frame_done", fd_tot - fd0, 0);
        rand_img();
        ref_pool(1'b0);
        base = res_q.size(); fd0 = fd_tot;
        run_frame(IW*IH, 1'b0, 1'b1, 1'b1, 15);
        check_results("after_reset", base, fd0, ON*ON);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
